fifo_sync_param: RTL and testbench

- Parametrised single-clock synchronous FIFO; successor to the fixed-size pop/push FIFO used between the datapath stages.
- Generalised data width and depth.
- Programmable almost-full/almost-empty thresholds using inequality, not equality.
- Exposes an occupancy count, sticky overflow/underflow error flags and a registered read-data valid strobe.
- Sits between a producer issuing push and a consumer issuing pop; downstream flow control keys on the almost_full/almost_empty flags.

---
 rtl/fifo_sync_param_pkg.sv | 18 +
 rtl/fifo_sync_param_mem.sv | 32 +++
 rtl/fifo_sync_param.sv | 103 ++++++++++
 tb/tb_fifo_sync_param.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sync_param_pkg.sv
// Shared constants for the parametrised synchronous FIFO and the status
// register that consumes its sticky error flags downstream.
package fifo_sync_param_pkg;

    localparam int ERR_OVF_BIT = 0;
    localparam int ERR_UDF_BIT = 1;
    localparam int ERR_W       = 2;

    // Count needs one extra bit so it can represent DEPTH itself.
    function automatic int cnt_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/fifo_sync_param_mem.sv
// Simple dual-port register array: one write port and one registered read
// port. The array itself is never reset; only the read register is.
module fifo_mem_2p #(
    parameter int DW = 10,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    // Read-before-write: a read and write to the same slot returns the old word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     rd_data_q <= '0;
        else if (rd_en) rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with occupancy count, threshold flags, sticky
// overflow/underflow and a registered read-data valid strobe.
module fifo_sync_param
    import fifo_sync_param_pkg::*;
#(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic [ADDR_WIDTH:0]   umbral_alto,
    input  logic [ADDR_WIDTH:0]   umbral_bajo,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full_fifo,
    output logic                  empty_fifo,
    output logic                  almost_full_fifo,
    output logic                  almost_empty_fifo,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  error_clr
);

    localparam int CW    = cnt_width(ADDR_WIDTH);
    localparam int DEPTH = fifo_depth(ADDR_WIDTH);
    localparam logic [CW-1:0]         DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]         CNT_ONE = CW'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [ERR_W-1:0]      err_q, err_d;
    logic                  dov_q;
    logic                  push_ok, pop_ok;

    assign full_fifo         = (count_q == DEPTH_C);
    assign empty_fifo        = (count_q == '0);
    assign almost_full_fifo  = (count_q >= umbral_alto);
    assign almost_empty_fifo = (count_q <= umbral_bajo);

    // A full FIFO still accepts a push when a pop frees a slot that cycle.
    assign pop_ok  = pop && !empty_fifo;
    assign push_ok = push && (!full_fifo || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (error_clr) err_d = '0;
        // Set after clear so a same-cycle error event wins.
        if (push && !push_ok) err_d[ERR_OVF_BIT] = 1'b1;
        if (pop && !pop_ok)   err_d[ERR_UDF_BIT] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= '0;
            dov_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
            dov_q    <= pop_ok;
        end
    end

    fifo_mem_2p #(
        .DW (DATA_WIDTH),
        .AW (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr_q),
        .wr_data (data_in),
        .rd_en   (pop_ok),
        .rd_addr (rd_ptr_q),
        .rd_data (data_out)
    );

    assign count          = count_q;
    assign data_out_valid = dov_q;
    assign overflow       = err_q[ERR_OVF_BIT];
    assign underflow      = err_q[ERR_UDF_BIT];

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param at DEPTH=8, DATA_WIDTH=10.
module tb_fifo_sync_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       push, pop, error_clr;
    logic [9:0] data_in;
    logic [9:0] data_out;
    logic       data_out_valid;
    logic [3:0] umbral_alto, umbral_bajo, count;
    logic       full_fifo, empty_fifo, almost_full_fifo, almost_empty_fifo;
    logic       overflow, underflow;

    int checks   = 0;
    int failures = 0;

    fifo_sync_param #(.DATA_WIDTH(10), .ADDR_WIDTH(3)) dut (
        .clk               (clk),
        .reset             (reset),
        .push              (push),
        .data_in           (data_in),
        .pop               (pop),
        .data_out          (data_out),
        .data_out_valid    (data_out_valid),
        .umbral_alto       (umbral_alto),
        .umbral_bajo       (umbral_bajo),
        .count             (count),
        .full_fifo         (full_fifo),
        .empty_fifo        (empty_fifo),
        .almost_full_fifo  (almost_full_fifo),
        .almost_empty_fifo (almost_empty_fifo),
        .overflow          (overflow),
        .underflow         (underflow),
        .error_clr         (error_clr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    logic [9:0] q[$];
    logic [9:0] exp_d;
    int         mcnt;
    int         mode;

    initial begin
        reset = 1'b0; push = 1'b0; pop = 1'b0; error_clr = 1'b0;
        data_in = '0; umbral_alto = 4'd6; umbral_bajo = 4'd2;

        // Reset state
        step(); step();
        chk("rst_count", count, 0);
        chk("rst_empty", empty_fifo, 1);
        chk("rst_full", full_fifo, 0);
        chk("rst_aempty", almost_empty_fifo, 1);
        chk("rst_afull", almost_full_fifo, 0);
        chk("rst_dout", data_out, 0);
        chk("rst_dov", data_out_valid, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_udf", underflow, 0);
        reset = 1'b1;
        step();

        // Fill 1..8, watch thresholds
        for (int i = 1; i <= 8; i++) begin
            push = 1'b1; data_in = 10'(i);
            step();
            chk("fill_count", count, i);
            chk("fill_afull", almost_full_fifo, (i >= 6) ? 1 : 0);
            chk("fill_full", full_fifo, (i == 8) ? 1 : 0);
        end
        push = 1'b0;

        // Drain: each word appears one cycle after its pop
        for (int i = 1; i <= 8; i++) begin
            pop = 1'b1;
            step();
            chk("drain_data", data_out, i);
            chk("drain_dov", data_out_valid, 1);
            chk("drain_count", count, 8 - i);
        end
        pop = 1'b0;
        step();
        chk("idle_dov", data_out_valid, 0);
        chk("idle_dout_hold", data_out, 10'h008);
        chk("idle_empty", empty_fifo, 1);

        // Refill, then overflow
        for (int i = 1; i <= 8; i++) begin
            push = 1'b1; data_in = 10'(i);
            step();
        end
        data_in = 10'h3FF;
        step();
        chk("ovf_flag", overflow, 1);
        chk("ovf_count", count, 8);
        chk("ovf_full", full_fifo, 1);

        // Push+pop while full
        data_in = 10'h155; pop = 1'b1;
        step();
        chk("full_pp_data", data_out, 10'h001);
        chk("full_pp_dov", data_out_valid, 1);
        chk("full_pp_count", count, 8);
        push = 1'b0; pop = 1'b0; error_clr = 1'b1;
        step();
        chk("clr_ovf", overflow, 0);
        error_clr = 1'b0;

        // Drain 2..8 then 0x155 (the dropped 0x3FF must not appear)
        for (int i = 2; i <= 9; i++) begin
            pop = 1'b1;
            step();
            chk("drain2_data", data_out, (i == 9) ? 10'h155 : 10'(i));
        end
        pop = 1'b0;
        chk("drain2_empty", empty_fifo, 1);

        // Empty: push+pop together, no fall-through
        push = 1'b1; pop = 1'b1; data_in = 10'h0AA;
        step();
        chk("empty_pp_count", count, 1);
        chk("empty_pp_udf", underflow, 1);
        chk("empty_pp_dov", data_out_valid, 0);
        push = 1'b0;
        step();
        chk("empty_pp_data", data_out, 10'h0AA);
        chk("empty_pp_dov2", data_out_valid, 1);
        chk("empty_pp_count2", count, 0);

        // Error set wins over same-cycle clear
        pop = 1'b1; error_clr = 1'b1;
        step();
        chk("set_wins_udf", underflow, 1);
        pop = 1'b0;
        step();
        chk("clr_udf", underflow, 0);
        error_clr = 1'b0;

        // Wrap: preload 3 words, then 20 mixed cycles keeping count in 2..5
        for (int i = 0; i < 3; i++) begin
            push = 1'b1; data_in = 10'h200 + 10'(i);
            q.push_back(data_in);
            step();
        end
        push = 1'b0;
        mcnt = 3;
        for (int k = 0; k < 20; k++) begin
            mode = k % 7;
            push = (mode >= 1 && mode <= 4);
            pop  = (mode == 0 || mode == 1 || mode >= 5);
            data_in = 10'h100 + 10'(k);
            exp_d = '0;
            if (pop)  exp_d = q.pop_front();
            if (push) q.push_back(data_in);
            mcnt = mcnt + (push ? 1 : 0) - (pop ? 1 : 0);
            step();
            if (pop) chk("wrap_data", data_out, exp_d);
            chk("wrap_count", count, mcnt);
            chk("wrap_aempty", almost_empty_fifo, (mcnt <= 2) ? 1 : 0);
        end
        push = 1'b0; pop = 1'b0;

        // Bring count to 5, then reset in the middle of a pop
        while (mcnt < 5) begin
            push = 1'b1; data_in = 10'h2F0;
            step();
            mcnt++;
        end
        push = 1'b0;
        chk("pre_rst_count", count, 5);
        pop = 1'b1;
        step();
        chk("pre_rst_dov", data_out_valid, 1);
        #2 reset = 1'b0;
        #1;
        chk("midrst_count", count, 0);
        chk("midrst_dov", data_out_valid, 0);
        chk("midrst_empty", empty_fifo, 1);
        chk("midrst_dout", data_out, 0);
        pop = 1'b0;
        step();
        reset = 1'b1;
        step();
        push = 1'b1; data_in = 10'h011;
        step();
        push = 1'b0; pop = 1'b1;
        step();
        pop = 1'b0;
        chk("post_rst_data", data_out, 10'h011);
        chk("post_rst_dov", data_out_valid, 1);
        chk("post_rst_count", count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
